// File: rtl/summation_pkg.sv
// Shared constants for the parameterised summation engine.
// FSM encodings and term-mode selectors.
package summation_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOOP  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] SPARE = 2'd3;

  localparam logic MODE_LIN = 1'b0;
  localparam logic MODE_SQR = 1'b1;

endpackage

// File: rtl/summation_term.sv
// Term generator plus saturating accumulate step.
// Purely combinational; sat flags any result above WIDTH bits.
module summation_term
  import summation_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NW    = 8
) (
  input  logic [NW-1:0]    i,
  input  logic             mode,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] next_acc,
  output logic             sat
);

  localparam int PW = 2 * NW;
  localparam int XW = ((PW > WIDTH) ? PW : WIDTH) + 1;

  logic [PW-1:0] ie;
  logic [PW-1:0] sq;
  logic [PW-1:0] term;
  logic [XW-1:0] tot;
  logic [XW-1:0] lim;

  // Build the term and add it with headroom so any overflow is visible
  always_comb begin
    ie   = PW'(i);
    sq   = ie * ie;
    term = ie;
    unique case (mode)
      MODE_LIN: term = ie;
      MODE_SQR: term = sq;
    endcase
    tot      = XW'(acc) + XW'(term);
    lim      = XW'({WIDTH{1'b1}});
    sat      = (tot > lim);
    next_acc = sat ? {WIDTH{1'b1}} : tot[WIDTH-1:0];
  end

endmodule

// File: rtl/param_summation.sv
// Sequential sum of i or i*i over i = 1..n.
// One accumulator, one counter, fixed n+1 cycle latency.
module param_summation
  import summation_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [NW-1:0]    n,
  output logic [WIDTH-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [NW-1:0]    i;
  logic [NW-1:0]    n_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] next_acc;
  logic             sat;
  logic             ovf;

  summation_term #(
    .WIDTH (WIDTH),
    .NW    (NW)
  ) u_term (
    .i        (i),
    .mode     (mode_reg),
    .acc      (acc),
    .next_acc (next_acc),
    .sat      (sat)
  );

  // Next-state decode; the spare code falls back to IDLE
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE: begin
        state_nx = IDLE;
        if (start) state_nx = (n == '0) ? DONE : LOOP;
      end
      LOOP:    state_nx = (i == n_reg) ? DONE : LOOP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, operand capture, accumulator and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      i        <= '0;
      n_reg    <= '0;
      mode_reg <= MODE_LIN;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_reg    <= n;
            mode_reg <= mode;
            i        <= NW'(1);
            acc      <= '0;
            ovf      <= 1'b0;
          end
        end
        LOOP: begin
          acc <= next_acc;
          i   <= i + 1'b1;
          if (sat) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum      = acc;
  assign busy     = (state == LOOP);
  assign done     = (state == DONE);
  assign overflow = ovf;

endmodule

// File: tb/tb_param_summation.sv
// Directed bench for param_summation at WIDTH=16 and WIDTH=8.
// Both instances share stimulus; each scenario checks its own width.
module tb_param_summation;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [7:0]  n;

  logic [15:0] sum16;
  logic        busy16, done16, ovf16;
  logic [7:0]  sum8;
  logic        busy8, done8, ovf8;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  param_summation #(.WIDTH(16), .NW(8)) u16 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .n        (n),
    .sum      (sum16),
    .busy     (busy16),
    .done     (done16),
    .overflow (ovf16)
  );

  param_summation #(.WIDTH(8), .NW(8)) u8 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .n        (n),
    .sum      (sum8),
    .busy     (busy8),
    .done     (done8),
    .overflow (ovf8)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Launch one run, scramble n/mode after the start cycle,
  // return done latency (-1 on timeout) and busy cycle count.
  task automatic run(input logic [7:0] nn, input logic m,
                     output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    n     = nn;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 8'hff;
    mode  = ~m;
    lat   = -1;
    bcnt  = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (busy16) bcnt++;
      if (done16) begin
        lat = c;
        break;
      end
    end
  endtask

  int   lat, bcnt;
  logic dd [1:12];
  logic bb [1:12];
  logic seen;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    n     = '0;
    #2;
    check("rst_sum",  32'(sum16),  0);
    check("rst_busy", 32'(busy16), 0);
    check("rst_done", 32'(done16), 0);
    check("rst_ovf",  32'(ovf16),  0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run(8'd10, 1'b0, lat, bcnt);
    check("lin10_lat",  32'(lat),   11);
    check("lin10_busy", 32'(bcnt),  10);
    check("lin10_sum",  32'(sum16), 55);
    check("lin10_ovf",  32'(ovf16), 0);

    run(8'd10, 1'b1, lat, bcnt);
    check("sqr10_lat", 32'(lat),   11);
    check("sqr10_sum", 32'(sum16), 385);
    check("sqr10_ovf", 32'(ovf16), 0);
    repeat (3) @(negedge clk);
    check("sqr10_hold", 32'(sum16),  385);
    check("idle_done",  32'(done16), 0);
    check("idle_busy",  32'(busy16), 0);

    run(8'd0, 1'b0, lat, bcnt);
    check("n0_lat",  32'(lat),   1);
    check("n0_busy", 32'(bcnt),  0);
    check("n0_sum",  32'(sum16), 0);

    run(8'd30, 1'b0, lat, bcnt);
    check("sat_lat",   32'(lat),   31);
    check("sat_done8", 32'(done8), 1);
    check("sat_sum8",  32'(sum8),  255);
    check("sat_ovf8",  32'(ovf8),  1);
    check("w16_sum",   32'(sum16), 465);
    check("w16_ovf",   32'(ovf16), 0);
    repeat (2) @(negedge clk);
    check("sat_hold_ovf", 32'(ovf8), 1);
    check("sat_hold_sum", 32'(sum8), 255);

    run(8'd3, 1'b0, lat, bcnt);
    check("clr_sum8", 32'(sum8), 6);
    check("clr_ovf8", 32'(ovf8), 0);

    // Start pulse with new operands in the middle of LOOP
    @(negedge clk);
    start = 1'b1;
    n     = 8'd10;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start = 1'b1;
        n     = 8'd3;
        mode  = 1'b1;
      end else if (c == 4) begin
        start = 1'b0;
      end
      if (done16) begin
        lat = c;
        break;
      end
    end
    check("mid_lat", 32'(lat),   11);
    check("mid_sum", 32'(sum16), 55);
    repeat (2) @(negedge clk);

    // Start held high through DONE gives back-to-back runs
    start = 1'b1;
    n     = 8'd3;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      dd[c] = done16;
      bb[c] = busy16;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      dd[c] = done16;
      bb[c] = busy16;
    end
    check("b2b_busy3", 32'(bb[3]), 1);
    check("b2b_done4", 32'(dd[4]), 1);
    check("b2b_idle5", 32'({bb[5], dd[5]}), 0);
    check("b2b_busy6", 32'(bb[6]), 1);
    check("b2b_done9", 32'(dd[9]), 1);
    check("b2b_sum",   32'(sum16), 6);
    repeat (2) @(negedge clk);

    // Reset asserted mid-LOOP at i=5
    @(negedge clk);
    start = 1'b1;
    n     = 8'd10;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_sum", 32'(sum16), 10);
    reset = 1'b0;
    #1;
    check("arst_sum",  32'(sum16),  0);
    check("arst_busy", 32'(busy16), 0);
    check("arst_done", 32'(done16), 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done16;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done16 | busy16;
    end
    check("arst_quiet", 32'(seen), 0);
    run(8'd4, 1'b0, lat, bcnt);
    check("post_rst_lat", 32'(lat),   5);
    check("post_rst_sum", 32'(sum16), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
